// File: rtl/cpu_pkg.sv
// Shared CPU definitions: fetch FSM states, default reset vector, instruction width.
package cpu_pkg;

  localparam int INST_W = 32;
  localparam logic [INST_W-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY    = 2'd1,
    DISCARD = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/fetch_fifo.sv
// Circular fetch buffer holding {instruction, pc+4}; head is read combinationally.
module fetch_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 64,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic             clear,
  input  logic [WIDTH-1:0] wdata,
  output logic [AW:0]      count,
  output logic [WIDTH-1:0] head
);

  logic [WIDTH-1:0] mem_reg [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [AW:0]      count_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem_reg[i] <= '0;
    end else if (push && !clear) begin
      mem_reg[wr_ptr_reg] <= wdata;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (clear) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      count_reg <= count_reg + (AW+1)'(push) - (AW+1)'(pop);
    end
  end

  assign count = count_reg;
  assign head  = mem_reg[rd_ptr_reg];

endmodule

// File: rtl/inst_fetch_unit.sv
// IF-stage fetch engine: PC generation, single-outstanding imem request FSM and fetch FIFO.
module inst_fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int          DEPTH    = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              redirect_valid,
  input  logic [31:0]       redirect_pc,
  output logic              imem_req,
  output logic [31:0]       imem_addr,
  input  logic              imem_ack,
  input  logic [INST_W-1:0] imem_rdata,
  output logic [INST_W-1:0] ReadInst,
  output logic [31:0]       IF_PC_Plus_4,
  output logic              if_flush
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  fetch_state_t state_reg, state_next;
  logic [31:0]  fetch_pc_reg, fetch_pc_next;
  logic [31:0]  req_pc_reg, req_pc_next;

  logic              push, pop, issue;
  logic [AW:0]       fifo_count;
  logic [63:0]       fifo_head;
  logic              fifo_empty;
  int                fill_after;

  assign fifo_empty = (fifo_count == '0);
  assign push       = imem_ack && (state_reg == BUSY) && !redirect_valid;
  assign pop        = !fifo_empty && !stall && !redirect_valid;
  assign fill_after = int'(fifo_count) + int'(push) - int'(pop);

  // Only issue when the returning word is guaranteed a FIFO slot.
  assign issue = !reset && !redirect_valid &&
                 ((state_reg == IDLE) || imem_ack) &&
                 (fill_after + 1 <= DEPTH);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg    <= IDLE;
      fetch_pc_reg <= RESET_PC;
      req_pc_reg   <= RESET_PC;
    end else begin
      state_reg    <= state_next;
      fetch_pc_reg <= fetch_pc_next;
      req_pc_reg   <= req_pc_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    fetch_pc_next = fetch_pc_reg;
    req_pc_next   = req_pc_reg;
    if (redirect_valid) begin
      fetch_pc_next = redirect_pc;
      state_next    = (state_reg != IDLE && !imem_ack) ? DISCARD : IDLE;
    end else if (issue) begin
      req_pc_next   = fetch_pc_reg;
      fetch_pc_next = fetch_pc_reg + 32'd4;
      state_next    = BUSY;
    end else if (imem_ack && state_reg != IDLE) begin
      state_next    = IDLE;
    end
  end

  fetch_fifo #(
    .DEPTH(DEPTH),
    .WIDTH(64)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .clear (redirect_valid),
    .wdata ({imem_rdata, req_pc_reg + 32'd4}),
    .count (fifo_count),
    .head  (fifo_head)
  );

  assign imem_req     = issue;
  assign imem_addr    = fetch_pc_reg;
  assign ReadInst     = fifo_empty ? '0 : fifo_head[63:32];
  assign IF_PC_Plus_4 = fifo_empty ? '0 : fifo_head[31:0];
  assign if_flush     = fifo_empty || stall || redirect_valid;

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Randomized bench for inst_fetch_unit against a queue-based fetch model and a variable-latency memory.
module tb_inst_fetch_unit;
  import cpu_pkg::*;

  localparam int          DEPTH  = 2;
  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam int          NCYC   = 1600;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] ReadInst;
  logic [31:0] IF_PC_Plus_4;
  logic        if_flush;

  inst_fetch_unit #(.RESET_PC(RST_PC), .DEPTH(DEPTH)) dut (
    .clk           (clk),
    .reset         (reset),
    .stall         (stall),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ack      (imem_ack),
    .imem_rdata    (imem_rdata),
    .ReadInst      (ReadInst),
    .IF_PC_Plus_4  (IF_PC_Plus_4),
    .if_flush      (if_flush)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
  endfunction

  // Reference model: delivered-instruction queue plus the one outstanding request.
  logic [63:0] mq[$];
  logic [63:0] head_e;
  logic        out_valid, out_kept;
  logic [31:0] out_pc, next_req;

  // Memory model
  logic        mem_pending;
  int          mem_wait;
  logic [31:0] mem_addr;

  int          rst_hold, stall_left, lat, sz;
  logic        m_push, m_pop, exp_issue, exp_flush;
  logic [31:0] exp_inst, exp_pc4;

  function automatic int pick_latency(input int c);
    if (c < 400) return 1;
    if (c < 700) return 3;
    return int'($urandom_range(1, 3));
  endfunction

  task automatic model_reset();
    mq.delete();
    out_valid = 1'b0;
    out_kept  = 1'b0;
    out_pc    = '0;
    next_req  = RST_PC;
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    imem_ack = 1'b0; imem_rdata = '0;
    mem_pending = 1'b0; mem_wait = 0; mem_addr = '0;
    rst_hold = 3; stall_left = 0;
    model_reset();

    for (cyc = 0; cyc < NCYC; cyc++) begin
      @(posedge clk); #1;
      // Reset: initial pulse, then occasional mid-run pulses favouring an outstanding request.
      if (rst_hold == 0 && cyc >= 700 && mem_pending && $urandom_range(0, 99) < 4)
        rst_hold = int'($urandom_range(1, 3));
      if (rst_hold > 0) begin
        reset = 1'b1;
        rst_hold--;
      end else begin
        reset = 1'b0;
      end

      if (reset) begin
        stall = 1'b0;
      end else if (stall_left > 0) begin
        stall = 1'b1;
        stall_left--;
      end else begin
        stall = 1'b0;
        if (cyc >= 100 && cyc < 400 && $urandom_range(0, 99) < 6) stall_left = 4;
        else if (cyc >= 400 && $urandom_range(0, 99) < 8) stall_left = int'($urandom_range(1, 5));
      end

      redirect_valid = 1'b0;
      redirect_pc    = $urandom & 32'hFFFF_FFFC;
      if (!reset && cyc >= 700 && $urandom_range(0, 99) < 7) begin
        redirect_valid = 1'b1;
        case ($urandom_range(0, 2))
          0: redirect_pc = 32'h0000_0100;
          1: redirect_pc = 32'hFFFF_FFF8;
          default: redirect_pc = $urandom & 32'h0000_FFFC;
        endcase
      end

      imem_ack   = 1'b0;
      imem_rdata = $urandom;
      if (!reset && mem_pending) begin
        if (mem_wait == 0) begin
          imem_ack   = 1'b1;
          imem_rdata = mem_word(mem_addr);
        end else begin
          mem_wait--;
        end
      end

      @(negedge clk);
      if (reset) begin
        chk("rst_req",   32'(imem_req), 32'd0);
        chk("rst_inst",  ReadInst, 32'd0);
        chk("rst_pc4",   IF_PC_Plus_4, 32'd0);
        chk("rst_flush", 32'(if_flush), 32'd1);
        chk("rst_addr",  imem_addr, RST_PC);
        model_reset();
        // A request caught by reset is answered right after release.
        if (mem_pending) mem_wait = 0;
      end else begin
        sz        = mq.size();
        m_push    = imem_ack && out_valid && out_kept && !redirect_valid;
        m_pop     = (sz != 0) && !stall && !redirect_valid;
        exp_issue = !redirect_valid && (!out_valid || imem_ack) &&
                    (sz + int'(m_push) - int'(m_pop) + 1 <= DEPTH);
        exp_flush = (sz == 0) || stall || redirect_valid;
        head_e    = (sz != 0) ? mq[0] : 64'd0;
        exp_inst  = head_e[63:32];
        exp_pc4   = head_e[31:0];

        chk("imem_req",  32'(imem_req), 32'(exp_issue));
        chk("imem_addr", imem_addr, next_req);
        chk("if_flush",  32'(if_flush), 32'(exp_flush));
        chk("ReadInst",  ReadInst, exp_inst);
        chk("pc_plus_4", IF_PC_Plus_4, exp_pc4);

        if (m_pop) begin
          $display("cycle %0d: deliver inst=%h pc+4=%h", cyc, exp_inst, exp_pc4);
          void'(mq.pop_front());
        end
        if (m_push) mq.push_back({mem_word(out_pc), out_pc + 32'd4});
        if (imem_ack && out_valid) out_valid = 1'b0;
        if (redirect_valid) begin
          mq.delete();
          if (out_valid) out_kept = 1'b0;
          next_req = redirect_pc;
        end else if (exp_issue) begin
          out_valid = 1'b1;
          out_kept  = 1'b1;
          out_pc    = next_req;
          next_req  = next_req + 32'd4;
        end
        if (mq.size() > DEPTH) chk("fifo_overflow", 32'(mq.size()), 32'(DEPTH));
      end

      // Memory side follows what the DUT actually requested.
      if (imem_ack) mem_pending = 1'b0;
      if (!reset && imem_req) begin
        if (mem_pending) chk("two_outstanding", 32'd1, 32'd0);
        lat         = pick_latency(cyc);
        mem_pending = 1'b1;
        mem_addr    = imem_addr;
        mem_wait    = lat - 1;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
